// File: rtl/prbs_checker_pkg.sv
// Shared types, default constants and PRBS helper functions for the PRBS checker.
package prbs_checker_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } prbsState_e;

  localparam int DEF_WIDTH    = 7;
  localparam int DEF_TAP      = 6;
  localparam int DEF_LOCK_CNT = 16;
  localparam int DEF_WIN      = 32;
  localparam int DEF_LOSS_CNT = 4;
  localparam int DEF_ERR_W    = 16;
  localparam int MAX_W        = 32;

  // XNOR feedback bit of an LFSR of the given length and second tap.
  function automatic logic prbsBit(input logic [MAX_W-1:0] s, input int width, input int tap);
    logic hi;
    logic lo;
    hi = 1'b0;
    lo = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == width - 1) hi = s[i];
      if (i == tap - 1)   lo = s[i];
    end
    return ~(hi ^ lo);
  endfunction

  // Next LFSR state: shift left and insert the feedback bit; bits above width are zero.
  function automatic logic [MAX_W-1:0] prbsNext(input logic [MAX_W-1:0] s, input int width,
                                                input int tap);
    logic [MAX_W-1:0] n;
    n = '0;
    n[0] = prbsBit(s, width, tap);
    for (int i = 1; i < MAX_W; i++) begin
      if (i < width) n[i] = s[i-1];
    end
    return n;
  endfunction

endpackage

// File: rtl/prbs_checker_lfsr.sv
// Receive-side LFSR: shifts in either the received bit (hunting) or its own
// prediction (locked), and exposes the predicted next bit plus a lockup flag.
module prbs_checker_lfsr
  import prbs_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAP   = DEF_TAP
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic shift_i,
  input  logic selD_i,
  input  logic d_i,
  output logic p_o,
  output logic allOnes_o
);

  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_d;
  logic             inBit;

  // Predicted next stream bit and the XNOR lockup (all-ones) indication.
  always_comb begin
    p_o       = prbsBit(MAX_W'(s_q), WIDTH, TAP);
    allOnes_o = &s_q;
  end

  // Choose what enters the register: received data while hunting, prediction while locked.
  always_comb begin
    inBit = selD_i ? d_i : p_o;
    s_d   = s_q;
    if (shift_i) s_d = {s_q[WIDTH-2:0], inBit};
  end

  // Shift register state.
  always_ff @(posedge clk_i) begin
    if (rst_i) s_q <= '0;
    else       s_q <= s_d;
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: hunts for alignment, locks, then flags and
// counts bit errors, dropping back to hunt when errors cluster in a window.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int TAP      = DEF_TAP,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int WIN      = DEF_WIN,
  parameter int LOSS_CNT = DEF_LOSS_CNT,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             dValid_i,
  input  logic             d_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_o,
  output logic             syncLoss_o,
  output logic [ERR_W-1:0] errCnt_o
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = $clog2(WIN + 1);
  localparam int BAD_W  = $clog2(LOSS_CNT + 1);

  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(WIDTH);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOSS_CNT - 1);

  prbsState_e        state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [BAD_W-1:0]  bad_q, bad_d;
  logic [ERR_W-1:0]  errCnt_q, errCnt_d;
  logic              err_q, err_d;
  logic              syncLoss_q, syncLoss_d;

  logic              predBit;
  logic              allOnes;
  logic              match;
  logic              errorNow;

  prbs_checker_lfsr #(
    .WIDTH(WIDTH),
    .TAP  (TAP)
  ) uLfsr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .shift_i  (dValid_i),
    .selD_i   (state_q == HUNT),
    .d_i      (d_i),
    .p_o      (predBit),
    .allOnes_o(allOnes)
  );

  // Next-state logic: hunt/lock FSM, sync counters, error flag and error counter.
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    good_d     = good_q;
    win_d      = win_q;
    bad_d      = bad_q;
    errCnt_d   = errCnt_q;
    err_d      = 1'b0;
    syncLoss_d = 1'b0;
    errorNow   = 1'b0;
    match      = (d_i == predBit);

    if (dValid_i) begin
      case (state_q)
        HUNT: begin
          if (fill_q != FILL_MAX) begin
            fill_d = fill_q + 1'b1;
          end else if (allOnes || !match) begin
            good_d = '0;
          end else if (good_q == GOOD_LAST) begin
            state_d = LOCK;
            good_d  = '0;
            win_d   = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        LOCK: begin
          errorNow = !match;
          if (!match && (bad_q == BAD_LAST)) begin
            state_d    = HUNT;
            syncLoss_d = 1'b1;
            fill_d     = '0;
            good_d     = '0;
            win_d      = '0;
            bad_d      = '0;
          end else if (win_q == WIN_LAST) begin
            win_d = '0;
            bad_d = '0;
          end else begin
            win_d = win_q + 1'b1;
            if (!match) bad_d = bad_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    err_d = errorNow;
    if (clr_i) begin
      errCnt_d = errorNow ? ERR_W'(1) : '0;
    end else if (errorNow && (errCnt_q != '1)) begin
      errCnt_d = errCnt_q + 1'b1;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= HUNT;
      fill_q     <= '0;
      good_q     <= '0;
      win_q      <= '0;
      bad_q      <= '0;
      errCnt_q   <= '0;
      err_q      <= 1'b0;
      syncLoss_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      good_q     <= good_d;
      win_q      <= win_d;
      bad_q      <= bad_d;
      errCnt_q   <= errCnt_d;
      err_q      <= err_d;
      syncLoss_q <= syncLoss_d;
    end
  end

  // Registered outputs.
  always_comb begin
    locked_o   = (state_q == LOCK);
    err_o      = err_q;
    syncLoss_o = syncLoss_q;
    errCnt_o   = errCnt_q;
  end

endmodule
